// File: rtl/format_detector_multi.sv
// VSYNC-period based NTSC/PAL detector: glitch rejection, multi-period agreement
// before lock or switch, and loss detection via a saturating period counter.
module format_detector_multi #(
  parameter int unsigned CNT_W      = 22,
  parameter int unsigned THRESHOLD  = 1_833_333,
  parameter int unsigned MIN_PERIOD = 1_000_000,
  parameter int unsigned TIMEOUT    = 4_000_000,
  parameter int unsigned NUM_AGREE  = 3,
  parameter int unsigned EDGE_POL   = 0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             vsync_in,
  output logic             format_valid,
  output logic             format_type,
  output logic             format_changed,
  output logic             signal_lost,
  output logic [CNT_W-1:0] period_out,
  output logic             period_strobe
);

  localparam int unsigned AGREE_W = 4;
  localparam logic [CNT_W-1:0]   THR_C   = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0]   MIN_C   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]   TMO_C   = CNT_W'(TIMEOUT);
  localparam logic [AGREE_W-1:0] AGREE_C = AGREE_W'(NUM_AGREE);
  localparam logic               POL_C   = 1'(EDGE_POL);
  localparam logic               FORMAT_NTSC = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCKED
  } state_t;

  state_t             state;
  logic               vsync_prev;
  logic [CNT_W-1:0]   cnt;
  logic               prev_class;
  logic [AGREE_W-1:0] agree_cnt;
  logic [AGREE_W-1:0] mismatch_cnt;

  logic               edge_det;
  logic               timeout_evt;
  logic               glitch;
  logic               cls;
  logic [AGREE_W-1:0] agree_next;
  logic [AGREE_W-1:0] mismatch_next;

  // Timeout fires once per loss: while signal_lost is high the saturated counter
  // must not keep re-firing, otherwise IDLE could never accept its first edge.
  always_comb begin
    edge_det      = 1'b0;
    timeout_evt   = 1'b0;
    glitch        = 1'b0;
    cls           = FORMAT_NTSC;
    agree_next    = AGREE_W'(1);
    mismatch_next = mismatch_cnt + AGREE_W'(1);
    if (POL_C) edge_det = !vsync_prev && vsync_in;
    else       edge_det = vsync_prev && !vsync_in;
    timeout_evt = (cnt == TMO_C) && !signal_lost;
    glitch      = cnt < MIN_C;
    cls         = cnt > THR_C;
    if (cls == prev_class) agree_next = agree_cnt + AGREE_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state          <= IDLE;
      vsync_prev     <= POL_C;
      cnt            <= '0;
      prev_class     <= FORMAT_NTSC;
      agree_cnt      <= '0;
      mismatch_cnt   <= '0;
      format_valid   <= 1'b0;
      format_type    <= FORMAT_NTSC;
      format_changed <= 1'b0;
      signal_lost    <= 1'b0;
      period_out     <= '0;
      period_strobe  <= 1'b0;
    end else begin
      vsync_prev     <= vsync_in;
      period_strobe  <= 1'b0;
      format_changed <= 1'b0;
      if (cnt != TMO_C) cnt <= cnt + CNT_W'(1);

      if (timeout_evt) begin
        // Edge coinciding with timeout is dropped; format_type is retained.
        state        <= IDLE;
        format_valid <= 1'b0;
        signal_lost  <= 1'b1;
        agree_cnt    <= '0;
        mismatch_cnt <= '0;
      end else if (edge_det) begin
        case (state)
          IDLE: begin
            cnt         <= CNT_W'(1);
            signal_lost <= 1'b0;
            agree_cnt   <= '0;
            state       <= MEASURE;
          end
          MEASURE: begin
            if (!glitch) begin
              cnt           <= CNT_W'(1);
              period_out    <= cnt;
              period_strobe <= 1'b1;
              prev_class    <= cls;
              if (agree_next >= AGREE_C) begin
                format_type  <= cls;
                format_valid <= 1'b1;
                agree_cnt    <= '0;
                mismatch_cnt <= '0;
                state        <= LOCKED;
              end else begin
                agree_cnt <= agree_next;
              end
            end
          end
          LOCKED: begin
            if (!glitch) begin
              cnt           <= CNT_W'(1);
              period_out    <= cnt;
              period_strobe <= 1'b1;
              if (cls == format_type) begin
                mismatch_cnt <= '0;
              end else if (mismatch_next >= AGREE_C) begin
                format_type    <= cls;
                format_changed <= 1'b1;
                mismatch_cnt   <= '0;
              end else begin
                mismatch_cnt <= mismatch_next;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_format_detector_multi.sv
// Scoreboard bench for format_detector_multi with scaled-down timing parameters
// (PAL period 200, NTSC 167, threshold 183, min 100, timeout 400).
module tb_format_detector_multi;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned THR   = 183;
  localparam int unsigned MINP  = 100;
  localparam int unsigned TMO   = 400;
  localparam int unsigned P_PAL = 200;
  localparam int unsigned P_NT  = 167;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             typ;
    logic             chg;
  } exp_t;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             vsync_in;
  logic             format_valid;
  logic             format_type;
  logic             format_changed;
  logic             signal_lost;
  logic [CNT_W-1:0] period_out;
  logic             period_strobe;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  format_detector_multi #(
    .CNT_W(CNT_W), .THRESHOLD(THR), .MIN_PERIOD(MINP),
    .TIMEOUT(TMO), .NUM_AGREE(3), .EDGE_POL(0)
  ) dut (
    .clk_in(clk_in), .rst(rst), .vsync_in(vsync_in),
    .format_valid(format_valid), .format_type(format_type),
    .format_changed(format_changed), .signal_lost(signal_lost),
    .period_out(period_out), .period_strobe(period_strobe)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One falling edge, then idle so the following edge lands `gap` cycles later.
  task automatic frame(input bit exp_strobe, input exp_t it, input int unsigned gap);
    if (exp_strobe) sb_q.push_back(it);
    vsync_in = 1'b0;
    @(negedge clk_in);
    vsync_in = 1'b1;
    @(negedge clk_in);
    check("strobe_drained", 32'(sb_q.size()), 32'd0);
    repeat (gap - 2) @(negedge clk_in);
  endtask

  function automatic exp_t mk(input int unsigned p, input bit v, input bit t, input bit c);
    exp_t e;
    e.period = CNT_W'(p);
    e.valid  = v;
    e.typ    = t;
    e.chg    = c;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(format_valid),   32'd0);
    check({tag, "_type"},    32'(format_type),    32'd0);
    check({tag, "_changed"}, 32'(format_changed), 32'd0);
    check({tag, "_lost"},    32'(signal_lost),    32'd0);
    check({tag, "_period"},  32'(period_out),     32'd0);
    check({tag, "_strobe"},  32'(period_strobe),  32'd0);
  endtask

  // Output side of the scoreboard.
  always @(negedge clk_in) begin
    if (!rst) begin
      if (period_strobe) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          check("period_out",     32'(period_out),     32'(mon_e.period));
          check("format_valid",   32'(format_valid),   32'(mon_e.valid));
          check("format_type",    32'(format_type),    32'(mon_e.typ));
          check("format_changed", 32'(format_changed), 32'(mon_e.chg));
        end
      end
      if (format_changed && !period_strobe)
        check("changed_without_strobe", 32'(period_strobe), 32'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk_in);

    // Lock onto PAL: first edge unreported, lock on the 4th edge.
    frame(0, '0, P_PAL);
    frame(1, mk(P_PAL, 0, 0, 0), P_PAL);
    frame(1, mk(P_PAL, 0, 0, 0), P_PAL);
    frame(1, mk(P_PAL, 1, 1, 0), P_PAL);
    // Glitch 5 cycles after a valid edge is ignored.
    frame(1, mk(P_PAL, 1, 1, 0), 5);
    frame(0, '0, P_PAL - 5);
    // Switch to NTSC after three NTSC periods.
    frame(1, mk(P_PAL, 1, 1, 0), P_NT);
    frame(1, mk(P_NT, 1, 1, 0), P_NT);
    frame(1, mk(P_NT, 1, 1, 0), P_NT);
    frame(1, mk(P_NT, 1, 0, 1), P_NT);
    // Outlier, recovery, then two PAL periods must not switch if mismatch reset.
    frame(1, mk(P_NT, 1, 0, 0), P_PAL);
    frame(1, mk(P_PAL, 1, 0, 0), P_NT);
    frame(1, mk(P_NT, 1, 0, 0), P_PAL);
    frame(1, mk(P_PAL, 1, 0, 0), P_PAL);
    frame(1, mk(P_PAL, 1, 0, 0), P_NT);
    // Threshold and minimum-period boundaries.
    frame(1, mk(P_NT, 1, 0, 0), THR);
    frame(1, mk(THR, 1, 0, 0), THR + 1);
    frame(1, mk(THR + 1, 1, 0, 0), MINP);
    frame(1, mk(MINP, 1, 0, 0), MINP - 1);
    frame(0, '0, P_NT - (MINP - 1));
    frame(1, mk(P_NT, 1, 0, 0), 2);

    // Loss: signal_lost rises exactly TMO cycles after the last edge.
    repeat (TMO - 2) @(negedge clk_in);
    check("lost_before_timeout",  32'(signal_lost),  32'd0);
    check("valid_before_timeout", 32'(format_valid), 32'd1);
    @(negedge clk_in);
    check("lost_at_timeout",  32'(signal_lost),  32'd1);
    check("valid_at_timeout", 32'(format_valid), 32'd0);
    check("type_held",        32'(format_type),  32'd0);

    // Recovery needs three further agreeing periods.
    frame(0, '0, P_PAL);
    check("lost_cleared", 32'(signal_lost), 32'd0);
    frame(1, mk(P_PAL, 0, 0, 0), P_PAL);
    frame(1, mk(P_PAL, 0, 0, 0), P_PAL);
    frame(1, mk(P_PAL, 1, 1, 0), TMO);
    // Edge in the same cycle as timeout is not a measurement.
    frame(0, '0, P_PAL);
    check("collide_lost",  32'(signal_lost),  32'd1);
    check("collide_valid", 32'(format_valid), 32'd0);
    frame(0, '0, P_PAL);
    check("collide_restart_lost", 32'(signal_lost), 32'd0);
    frame(1, mk(P_PAL, 0, 1, 0), 50);

    // Reset in the middle of MEASURE.
    rst = 1'b1;
    @(negedge clk_in);
    check_reset_outputs("midreset");
    rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/format_detector_multi.md
# format_detector_multi

Parametrised NTSC/PAL format detector for the SAVO MAX video front end, measuring the VSYNC period in `clk_in` cycles. It runs continuously rather than latching after one decision, and rejects glitch edges shorter than a minimum period. A format is declared only after `NUM_AGREE` consecutive agreeing periods, a later format change is tracked and flagged, and `format_valid` drops with a loss indication when VSYNC disappears. The block sits between the sync separator and the mode-select logic and exports the raw period for diagnostics.

## Interface

- `CNT_W`, 22: period counter width; must hold `TIMEOUT`.
- `THRESHOLD`, 1_833_333: period in cycles (18.33 ms at 100 MHz); a period strictly greater than this classifies as PAL, otherwise NTSC.
- `MIN_PERIOD`, 1_000_000: a period strictly less than this is a glitch edge and is ignored.
- `TIMEOUT`, 4_000_000: cycles without an accepted edge before the signal is declared lost.
- `NUM_AGREE`, 3: consecutive same-class periods required to lock or to switch format; range 1..15.
- `EDGE_POL`, 0: 0 = falling edge of `vsync_in` marks a frame, 1 = rising edge.
- `clk_in`  input  1: system clock.
- `rst`  input  1: synchronous, active-high reset.
- `vsync_in`  input  1: VSYNC, already synchronised to `clk_in`.
- `format_valid`  output  1: format is locked.
- `format_type`  output  1: `FORMAT_NTSC` (0) or `FORMAT_PAL` (1); meaningful only while `format_valid` is high.
- `format_changed`  output  1: one-cycle pulse when a locked format switches type.
- `signal_lost`  output  1: level; high after a timeout, cleared by the next accepted edge.
- `period_out`  output  CNT_W: last accepted period.
- `period_strobe`  output  1: one-cycle pulse when `period_out` updates.

## Operation

- **Edge detect:** `vsync_prev` holds `vsync_in` from the previous cycle. With `EDGE_POL` = 0, an edge is `vsync_prev & !vsync_in`; with `EDGE_POL` = 1 it is the inverse.
- **Counter:**
  - Counts up every cycle from reset and saturates at `TIMEOUT`.
  - On an accepted edge it loads 1, so the counter value at the next edge equals the period in cycles.
- **Glitch rejection:** in state MEASURE or LOCKED, an edge with counter < `MIN_PERIOD` is ignored entirely. The counter keeps running and no output changes.
- **States:**
  - **IDLE:** entered at reset and on timeout. The first edge is accepted, the counter loads 1, `signal_lost` clears and the state moves to MEASURE. No period is reported for this edge.
  - **MEASURE:** on each accepted edge:
    - `period_out` takes the counter value and `period_strobe` pulses.
    - The period is classified as PAL or NTSC.
    - `agree_cnt` increments if the class equals the previous class; otherwise `agree_cnt` is set to 1 and the previous class is updated.
    - When `agree_cnt` reaches `NUM_AGREE`, `format_type` takes the class, `format_valid` goes to 1 and the state moves to LOCKED.
  - **LOCKED:** periods are measured and strobed as in MEASURE.
    - A class equal to `format_type` clears `mismatch_cnt` to 0.
    - A differing class increments `mismatch_cnt`. When it reaches `NUM_AGREE`, `format_type` flips, `format_changed` pulses, `mismatch_cnt` clears, and `format_valid` stays high.
- **Timeout:** when the counter reaches `TIMEOUT` in any state without an accepted edge:
  - `format_valid` goes to 0 and `signal_lost` to 1.
  - `agree_cnt` and `mismatch_cnt` clear and the state moves to IDLE.
  - `format_type` holds its last value.
- **Simultaneous events:** an edge in the same cycle the counter reaches `TIMEOUT` is handled as a timeout. The edge is not a measurement; the block enters IDLE and the next edge restarts measurement.
- **Reset mid-operation:** everything returns to reset values the following cycle regardless of state.

## Timing

- **Reset values:**
  - `format_valid` = 0, `format_type` = NTSC, `format_changed` = 0, `signal_lost` = 0, `period_out` = 0, `period_strobe` = 0.
  - Counter = 0, state IDLE.
- **Latency:**
  - All outputs are registered.
  - `period_strobe`, `period_out`, `format_valid`, `format_type` and `format_changed` update on the clock edge after the cycle in which the edge condition is true.
  - `signal_lost` rises one cycle after the counter reaches `TIMEOUT`.
- **Pulse width:** `format_changed` and `period_strobe` are exactly one cycle wide.
- **Classification boundaries:** a period equal to `THRESHOLD` classifies as NTSC. A period equal to `MIN_PERIOD` is accepted.

## Test plan

- **Lock:** after reset, falling edges every 2_000_000 cycles (50 Hz). Required: no strobe on the first edge; strobes on edges 2, 3 and 4 with `period_out` = 2_000_000; `format_valid` = 1 and `format_type` = PAL one cycle after edge 4.
- **Switch:** with the block locked PAL, change to 1_666_667-cycle periods (60 Hz). Required: `format_changed` pulses once, after the 3rd NTSC period; `format_type` = NTSC; `format_valid` never drops.
- **Glitch:** locked at PAL, inject an extra edge 5_000 cycles after a valid edge. Required: no strobe, no state change, and the next `period_out` = 2_000_000.
- **Single outlier:** locked NTSC, feed one 2_000_000-cycle period between NTSC periods. Required: no `format_changed`, and `mismatch_cnt` resets on the following NTSC period.
- **Loss and recovery:** stop VSYNC while locked. Required: `format_valid` = 0 and `signal_lost` = 1 exactly 4_000_000 cycles after the last edge. When edges restart, `signal_lost` clears on the first edge and lock needs 3 further agreeing periods.
- **Boundary and reset:** a period of exactly 1_833_333 classifies as NTSC. Asserting `rst` mid-MEASURE returns all outputs to their reset values the next cycle.
